stoch_encoder: RTL
==================

# stoch_encoder

Binary-to-stochastic encoder that consumes the `jkiss` random-word stream to turn a fixed-point probability into a unipolar stochastic bitstream of programmable length. It is the initiator side of the RNG interface. It drives `seed`/`re_seed` into a `jkiss` instance and samples its `rnd` output. It sits between a request source (valid/ready) and a downstream stochastic datapath (valid/ready bitstream).

## Interface
- `RND_W`, default 32: width of `rng_rnd` and `rng_seed`.
- `VAL_W`, default 16: probability width, where P = `in_value` / 2^VAL_W. Must be ≤ `RND_W`.
- `LEN_W`, default 16: stream-length width.
- `WARMUP`, default 2: cycles waited after `re_seed` before sampling; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accept; high only in IDLE.
- `in_value` in VAL_W: probability numerator.
- `in_len` in LEN_W: number of bits to emit.
- `in_seed` in RND_W: seed forwarded to the RNG.
- `rng_seed` out RND_W: to `jkiss.seed`.
- `rng_re_seed` out 1: to `jkiss.re_seed`.
- `rng_rnd` in RND_W: from `jkiss.rnd`.
- `bit_valid` out 1: stream bit valid.
- `bit_data` out 1: stream bit.
- `bit_last` out 1: final bit of the stream.
- `bit_ready` in 1: downstream accept.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, SEED, WARM, STREAM.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_value`, `in_len` and `in_seed`.
  - If `in_len`==0: stay in IDLE, with no reseed and no bits.
  - Otherwise go to SEED.
- **SEED** (1 cycle)
  - `rng_re_seed`=1 and `rng_seed`=latched seed.
  - Go to WARM and load the warm counter with WARMUP-1.
- **WARM**
  - Count down.
  - At count 0: load the output register with the first bit and go to STREAM.
- **Bit rule**: bit = (`rng_rnd[RND_W-1 -: VAL_W]` < value), an unsigned compare.
  - value=0 always gives 0.
  - value=2^VAL_W-1 gives 1 except when the sampled word's top bits are all ones.
- **STREAM**
  - `bit_valid`=1. The register holds while `bit_ready`=0.
  - On handshake with remaining > 1: load the next bit from the current `rng_rnd` on the same edge and decrement remaining.
  - On handshake of the last bit: go to IDLE.
  - RNG words that advance during a stall are discarded (decided).
- `bit_last` = (remaining == 1) while `bit_valid`.
- `rng_seed` holds its last value outside SEED; `rng_re_seed`=0 outside SEED.

## Timing
- Reset values:
  - `in_ready`=0 during reset, then 1 on the first cycle out of reset.
  - `rng_seed`=0, `rng_re_seed`=0, `bit_valid`=0, `bit_data`=0, `bit_last`=0, `busy`=0.
  - State returns to IDLE.
- Accept at edge T0:
  - `rng_re_seed` is high in cycle T0..T1.
  - `bit_valid` first rises at edge T1+WARMUP (WARMUP+1 edges after accept).
  - The first bit reflects the `rng_rnd` present at that edge.
- Throughput: 1 bit/cycle with `bit_ready` tied high.
- After the last handshake at edge Tn:
  - `bit_valid`=0 and `in_ready`=1 from Tn.
  - A new request may be accepted at Tn+1.
- `rst` mid-stream:
  - All outputs return to reset values on that edge and the stream is abandoned.
  - The RNG is not reseeded.
- `in_valid` held in a busy state is ignored, because `in_ready`=0.

## Configuration
- `STOCH_ENCODER_ONES_COUNT_EN` defined:
  - Adds output `ones_count` [LEN_W].
  - It is cleared on request accept and incremented on each handshaked bit with `bit_data`=1.
  - It holds its final value in IDLE; reset value is 0.
- Undefined: the port and its counter are absent, and behaviour is otherwise identical.

## Structure
- Package `stoch_pkg`:
  - state enum (IDLE/SEED/WARM/STREAM);
  - default WARMUP constant;
  - a helper function computing P from VAL_W for benches.
- Sub-module `stoch_cmp`: top-slice extraction plus unsigned comparator producing one bit. It is shared with future bipolar encoders.
- The FSM, counters and output register live in the top module.

## Test plan
- `rng_rnd` stubbed at 0x0000_0000, value=1, len=8, `bit_ready`=1 → 8 ones on consecutive cycles, `bit_last` on the 8th, `in_ready` back high the next cycle.
- Stub 0xFFFF_FFFF, value=0xFFFF, len=4 → 4 zeros; with the macro defined, `ones_count`=0.
- Real `jkiss`, `in_seed`=0xDEAD_BEEF, WARMUP=2 → `rng_re_seed` pulses exactly one cycle with `rng_seed`=0xDEADBEEF. The first bit equals (top 16 bits of the first post-reseed `rnd`, 2778845915) < value.
- len=5, `bit_ready` toggled 1,0,0,1,... → exactly 5 handshakes, `bit_data` stable across stalls, `bit_last` only on the 5th.
- len=0 request → `in_ready` stays high, no `rng_re_seed` pulse, no `bit_valid`.
- `rst` asserted in the third STREAM cycle of len=100 → next cycle all outputs at reset values. A new request then completes normally.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic encoders.
package stoch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    WARM,
    STREAM
  } state_e;

  localparam int WARMUP_DEFAULT = 2;

  // Probability represented by a VAL_W-bit numerator: value / 2^val_w.
  function automatic real prob_of(input longint unsigned value, input int unsigned val_w);
    return real'(value) / (2.0 ** val_w);
  endfunction

endpackage

// File: rtl/stoch_encoder_if.sv
// Request, RNG and bitstream signals of the stochastic encoder.
interface stoch_encoder_if #(
  parameter int RND_W = 32,
  parameter int VAL_W = 16,
  parameter int LEN_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] in_value;
  logic [LEN_W-1:0] in_len;
  logic [RND_W-1:0] in_seed;
  logic [RND_W-1:0] rng_seed;
  logic             rng_re_seed;
  logic [RND_W-1:0] rng_rnd;
  logic             bit_valid;
  logic             bit_data;
  logic             bit_last;
  logic             bit_ready;
  logic             busy;

  modport master (
    input  in_valid, in_value, in_len, in_seed, rng_rnd, bit_ready,
    output in_ready, rng_seed, rng_re_seed, bit_valid, bit_data, bit_last, busy
  );

  modport slave (
    output in_valid, in_value, in_len, in_seed, rng_rnd, bit_ready,
    input  in_ready, rng_seed, rng_re_seed, bit_valid, bit_data, bit_last, busy
  );

endinterface

// File: rtl/stoch_cmp.sv
// One stochastic bit: top VAL_W bits of the random word compared unsigned against the value.
module stoch_cmp #(
  parameter int RND_W = 32,
  parameter int VAL_W = 16
) (
  input  logic [RND_W-1:0] rnd_i,
  input  logic [VAL_W-1:0] value_i,
  output logic             bit_o
);

  assign bit_o = (rnd_i[RND_W-1 -: VAL_W] < value_i);

  if (VAL_W < RND_W) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^rnd_i[RND_W-VAL_W-1:0];
  end

endmodule

// File: rtl/stoch_encoder.sv
// Binary-to-unipolar-stochastic encoder driving a jkiss RNG; first bit WARMUP+1 edges after accept,
// bit register holds under bit_ready=0. Optional ones_count output with STOCH_ENCODER_ONES_COUNT_EN.
module stoch_encoder
  import stoch_pkg::*;
#(
  parameter int RND_W  = 32,
  parameter int VAL_W  = 16,
  parameter int LEN_W  = 16,
  parameter int WARMUP = WARMUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  stoch_encoder_if.master  enc_io
`ifdef STOCH_ENCODER_ONES_COUNT_EN
  ,
  output logic [LEN_W-1:0] ones_count
`endif
);

  localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_e            state_q, state_d;
  logic [VAL_W-1:0]  value_q, value_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [RND_W-1:0]  seed_q, seed_d;
  logic [WCNT_W-1:0] warm_q, warm_d;
  logic              bit_q, bit_d;
  logic              cmp_bit;
  logic              accept;
  logic              hs;

  stoch_cmp #(
    .RND_W(RND_W),
    .VAL_W(VAL_W)
  ) u_cmp (
    .rnd_i  (enc_io.rng_rnd),
    .value_i(value_q),
    .bit_o  (cmp_bit)
  );

  assign enc_io.in_ready    = (state_q == IDLE) && !rst;
  assign enc_io.rng_seed    = seed_q;
  assign enc_io.rng_re_seed = (state_q == SEED);
  assign enc_io.bit_valid   = (state_q == STREAM);
  assign enc_io.bit_data    = bit_q;
  assign enc_io.bit_last    = (state_q == STREAM) && (remain_q == LEN_W'(1));
  assign enc_io.busy        = (state_q != IDLE);

  assign accept = enc_io.in_valid && enc_io.in_ready;
  assign hs     = (state_q == STREAM) && enc_io.bit_ready;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    remain_d = remain_q;
    seed_d   = seed_q;
    warm_d   = warm_q;
    bit_d    = bit_q;
    case (state_q)
      IDLE: begin
        // Zero-length requests are consumed without touching the RNG.
        if (accept && (enc_io.in_len != '0)) begin
          value_d  = enc_io.in_value;
          remain_d = enc_io.in_len;
          seed_d   = enc_io.in_seed;
          state_d  = SEED;
        end
      end
      SEED: begin
        warm_d  = WCNT_W'(WARMUP - 1);
        state_d = WARM;
      end
      WARM: begin
        if (warm_q == '0) begin
          bit_d   = cmp_bit;
          state_d = STREAM;
        end else begin
          warm_d = warm_q - WCNT_W'(1);
        end
      end
      STREAM: begin
        // Words produced while stalled are dropped; the next bit uses the word at the handshake.
        if (hs) begin
          if (remain_q == LEN_W'(1)) begin
            state_d = IDLE;
          end else begin
            bit_d    = cmp_bit;
            remain_d = remain_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      value_q  <= '0;
      remain_q <= '0;
      seed_q   <= '0;
      warm_q   <= '0;
      bit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      remain_q <= remain_d;
      seed_q   <= seed_d;
      warm_q   <= warm_d;
      bit_q    <= bit_d;
    end
  end

`ifdef STOCH_ENCODER_ONES_COUNT_EN
  logic [LEN_W-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (accept) begin
      ones_d = '0;
    end else if (hs && bit_q) begin
      ones_d = ones_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_count = ones_q;
`endif

endmodule
